// File: rtl/score_status_tracker.sv
// -----------------------------------------------------------------------------
// score_status_tracker
//
// Game-status stage that sits in front of the seven-segment display driver.
// It tracks the IDLE/PLAY/LOST game state, keeps a 4-digit BCD score and a
// best score, and generates the digit-scan tick and blink phase the display
// needs.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle pulse: begin a new game (IDLE or LOST only)
//   pipe_passed  one-cycle pulse: bird cleared a pipe (scores in PLAY)
//   collision    one-cycle pulse: bird crashed (PLAY -> LOST)
//   lost         high while in LOST
//   playing      high while in PLAY
//   score_bcd    current score, 4 BCD digits, [15:12] = thousands
//   best_bcd     best score since reset, 4 BCD digits
//   scan_tick    one-cycle pulse every SCAN_DIV cycles
//   blink_phase  lost-message phase: 0 = "YOU", 2 = "LOSE", 1/3 = blank
//   state_dbg    current FSM state (0 = IDLE, 1 = PLAY, 2 = LOST)
//
// Handshake: start, pipe_passed and collision are single-cycle event
// strobes with no back-pressure; each is consumed on the edge where it is
// high, and is simply ignored if the current state does not act on it.
// -----------------------------------------------------------------------------
module score_status_tracker #(
   parameter int unsigned SCAN_DIV  = 262144,
   parameter int unsigned BLINK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pipe_passed,
   input  logic        collision,
   output logic        lost,
   output logic        playing,
   output logic [15:0] score_bcd,
   output logic [15:0] best_bcd,
   output logic        scan_tick,
   output logic [1:0]  blink_phase,
   output logic [1:0]  state_dbg
);

   localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_LOST = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         score_q, score_d;
   logic [15:0]         best_q, best_d;
   logic [15:0]         score_inc;
   logic                lost_q, lost_d;
   logic                playing_q, playing_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic                scan_tick_q, scan_tick_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic [1:0]          blink_phase_q, blink_phase_d;
   logic                carry;

   // BCD +1 with a ripple carry across the four digits.
   always_comb begin
      score_inc = score_q;
      carry     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (score_q[i*4 +: 4] >= 4'd9) begin
               score_inc[i*4 +: 4] = 4'd0;
            end else begin
               score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   // Next state, score and best score.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      best_d  = best_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PLAY;
               score_d = 16'h0000;
            end
         end
         ST_PLAY: begin
            // collision has priority over a simultaneous pipe_passed.
            if (collision) begin
               state_d = ST_LOST;
               // Nibbles never exceed 9, so a plain unsigned compare of the
               // packed BCD word orders scores the same as a digit-wise compare.
               if (score_q > best_q) best_d = score_q;
            end else if (pipe_passed && (score_q != 16'h9999)) begin
               score_d = score_inc;
            end
         end
         ST_LOST: begin
            if (start) begin
               state_d = ST_PLAY;
               score_d = 16'h0000;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status flags, scan divider and blink divider.
   always_comb begin
      lost_d    = (state_d == ST_LOST);
      playing_d = (state_d == ST_PLAY);

      scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);
      scan_tick_d = (scan_cnt_d == SCAN_LAST);

      blink_cnt_d   = '0;
      blink_phase_d = 2'd0;
      // Only count while staying in LOST; the entry edge leaves both at 0.
      if ((state_q == ST_LOST) && (state_d == ST_LOST)) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = blink_phase_q + 2'd1;
         end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
            blink_phase_d = blink_phase_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         score_q       <= 16'h0000;
         best_q        <= 16'h0000;
         lost_q        <= 1'b0;
         playing_q     <= 1'b0;
         scan_cnt_q    <= '0;
         scan_tick_q   <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 2'd0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         best_q        <= best_d;
         lost_q        <= lost_d;
         playing_q     <= playing_d;
         scan_cnt_q    <= scan_cnt_d;
         scan_tick_q   <= scan_tick_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign lost        = lost_q;
   assign playing     = playing_q;
   assign score_bcd   = score_q;
   assign best_bcd    = best_q;
   assign scan_tick   = scan_tick_q;
   assign blink_phase = blink_phase_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_score_status_tracker.sv
// -----------------------------------------------------------------------------
// tb_score_status_tracker
//
// Bench for score_status_tracker with SCAN_DIV=4, BLINK_DIV=8. A reference
// model (integer score, cycle-age based blink/scan) computes the expected
// output vector for every driven cycle; it is pushed to exp_q and popped
// and compared field by field after the following clock edge.
// -----------------------------------------------------------------------------
module tb_score_status_tracker;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;
   localparam int W         = 39;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pipe_passed = 1'b0;
   logic        collision = 1'b0;
   logic        lost;
   logic        playing;
   logic [15:0] score_bcd;
   logic [15:0] best_bcd;
   logic        scan_tick;
   logic [1:0]  blink_phase;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   score_status_tracker #(
      .SCAN_DIV (SCAN_DIV),
      .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pipe_passed(pipe_passed),
      .collision  (collision),
      .lost       (lost),
      .playing    (playing),
      .score_bcd  (score_bcd),
      .best_bcd   (best_bcd),
      .scan_tick  (scan_tick),
      .blink_phase(blink_phase),
      .state_dbg  (state_dbg)
   );

   initial begin
      #10ms;
      $display("FAIL timeout: simulation did not finish (got running, need done)");
      $fatal(1, "timeout");
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_state = 0;     // 0 IDLE, 1 PLAY, 2 LOST
   int m_score = 0;
   int m_best  = 0;
   int m_scan  = 0;     // edges since reset
   int m_age   = 0;     // edges since entering LOST

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_step(input logic r, input logic st, input logic pp, input logic co);
      if (r) begin
         m_state = 0; m_score = 0; m_best = 0; m_scan = 0; m_age = 0;
      end else begin
         m_scan = m_scan + 1;
         case (m_state)
            0: if (st) begin m_state = 1; m_score = 0; end
            1: begin
               if (co) begin
                  m_state = 2;
                  m_age = 0;
                  if (m_score > m_best) m_best = m_score;
               end else if (pp && m_score < 9999) begin
                  m_score = m_score + 1;
               end
            end
            default: begin
               if (st) begin m_state = 1; m_score = 0; end
               else m_age = m_age + 1;
            end
         endcase
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] model_vec();
      logic [1:0] ph;
      logic       tk;
      ph = (m_state == 2) ? 2'((m_age / BLINK_DIV) % 4) : 2'd0;
      tk = ((m_scan % SCAN_DIV) == SCAN_DIV - 1);
      return {2'(m_state), (m_state == 2), (m_state == 1),
              to_bcd(m_score), to_bcd(m_best), ph, tk};
   endfunction

   task automatic compare_out();
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("state",       32'(state_dbg),   32'(e[38:37]));
      check("lost",        32'(lost),        32'(e[36]));
      check("playing",     32'(playing),     32'(e[35]));
      check("score_bcd",   32'(score_bcd),   32'(e[34:19]));
      check("best_bcd",    32'(best_bcd),    32'(e[18:3]));
      check("blink_phase", 32'(blink_phase), 32'(e[2:1]));
      check("scan_tick",   32'(scan_tick),   32'(e[0]));
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic st, input logic pp, input logic co);
      @(negedge clk);
      rst = r; start = st; pipe_passed = pp; collision = co;
      model_step(r, st, pp, co);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pipe();
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int tick_cnt;

      // 1: reset and idle; scan tick every 4th cycle
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_score", 32'(score_bcd), 32'h0);
      check("reset_lost", 32'(lost), 32'd0);
      tick_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (scan_tick) tick_cnt++;
         if (i == 3) check("first_tick", 32'(scan_tick), 32'd1);
      end
      check("tick_count_20", 32'(tick_cnt), 32'd5);

      // 2: start, carry 9->10, 13 pipes, start ignored in PLAY
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) pipe();
      check("score_10", 32'(score_bcd), 32'h0010);
      for (int i = 0; i < 3; i++) pipe();
      check("score_13", 32'(score_bcd), 32'h0013);
      check("playing_13", 32'(playing), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("start_in_play", 32'(score_bcd), 32'h0013);

      // 3: carry chain and saturation
      while (m_score < 999) pipe();
      check("score_0999", 32'(score_bcd), 32'h0999);
      pipe();
      check("score_1000", 32'(score_bcd), 32'h1000);
      while (m_score < 9999) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         pipe();
      end
      pipe();
      pipe();
      check("score_sat", 32'(score_bcd), 32'h9999);

      // 4: game over at 5, blink sequence, pipes ignored in LOST
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) pipe();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("lost_after_col", 32'(lost), 32'd1);
      check("playing_after_col", 32'(playing), 32'd0);
      check("best_5", 32'(best_bcd), 32'h0005);
      for (int i = 0; i < 4 * BLINK_DIV + 4; i++) begin
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (i == BLINK_DIV - 1)     check("phase_1", 32'(blink_phase), 32'd1);
         if (i == 3 * BLINK_DIV - 1) check("phase_3", 32'(blink_phase), 32'd3);
         if (i == 4 * BLINK_DIV - 1) check("phase_wrap", 32'(blink_phase), 32'd0);
      end
      check("score_held_lost", 32'(score_bcd), 32'h0005);

      // 5: simultaneous collision + pipe at 7, then lower score keeps best
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("blink_reset_play", 32'(blink_phase), 32'd0);
      for (int i = 0; i < 7; i++) pipe();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("simul_score", 32'(score_bcd), 32'h0007);
      check("simul_best", 32'(best_bcd), 32'h0007);
      check("simul_lost", 32'(lost), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pipe();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("low_score", 32'(score_bcd), 32'h0003);
      check("best_kept", 32'(best_bcd), 32'h0007);

      // 6: reset mid-LOST at blink phase 2
      idle(2 * BLINK_DIV);
      check("phase_2", 32'(blink_phase), 32'd2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_best", 32'(best_bcd), 32'h0);
      check("rst_blink", 32'(blink_phase), 32'd0);

      // random event mix
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 24) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/score_status_tracker.md
Name: score_status_tracker

Overview:
- Game-status stage directly upstream of the seven-segment display driver.
- Tracks the play/lost game state and keeps a 4-digit BCD score and a best score.
- Generates the two timing signals the display consumes: a digit-scan tick and a 2-bit blink phase for the lost-message sequence.
- Driven by the bird/pipe logic through single-cycle event pulses.

Parameters:
- SCAN_DIV, 262144: clock cycles per scan_tick pulse; legal range ≥ 2.
- BLINK_DIV, 50000000: clock cycles per blink_phase step; legal range ≥ 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin a new game.
- pipe_passed  input  1  one-cycle pulse: bird cleared a pipe.
- collision  input  1  one-cycle pulse: bird hit a pipe or the ground.
- lost  output  1  high while in LOST; feeds the display lost input.
- playing  output  1  high while in PLAY.
- score_bcd  output  16  current score, 4 BCD digits, [15:12] = thousands.
- best_bcd  output  16  best score since reset, 4 BCD digits.
- scan_tick  output  1  one-cycle pulse every SCAN_DIV cycles; display digit-advance enable.
- blink_phase  output  2  lost-message phase; 0 = "YOU", 2 = "LOSE", 1 and 3 = blank.

Behaviour:
- Reset (clk edge with rst=1):
  - state = IDLE.
  - lost, playing, scan_tick = 0.
  - score_bcd, best_bcd, blink_phase = 0.
  - Both divider counters = 0.
  - Reset mid-game discards everything; best_bcd is not retained.
- State machine, all transitions registered:
  - IDLE: start → PLAY; the score is cleared on entry.
  - PLAY: collision → LOST. start is ignored in PLAY.
  - LOST: start → PLAY; score cleared, blink_phase = 0.
  - Events that are not listed for the current state are ignored.
- Outputs:
  - Registered and decoded from the next state, so they change on the same edge as the transition.
  - lost = (state == LOST); playing = (state == PLAY).
- Score:
  - In PLAY, pipe_passed increments score_bcd by 1 on the next edge.
  - Each nibble wraps 9→0 with a carry into the next digit.
  - At 9999 the score saturates and further increments are ignored.
  - Nibbles never hold values above 9.
- Simultaneous events in PLAY:
  - collision together with pipe_passed: collision wins. The game moves to LOST and the score is not incremented.
- Best score:
  - On the edge entering LOST, best_bcd is loaded with the final score_bcd if it is strictly greater than best_bcd.
  - Compare the BCD values digit-wise from the most significant digit (this equals a numeric compare).
- Scan divider:
  - Free-running counter 0..SCAN_DIV-1, active in all states.
  - scan_tick = 1 for exactly the one cycle in which the counter equals SCAN_DIV-1; the counter then wraps to 0.
  - Period is exactly SCAN_DIV cycles.
- Blink divider:
  - Counts only in LOST, 0..BLINK_DIV-1.
  - At BLINK_DIV-1 the counter wraps and blink_phase increments mod 4.
  - On entering LOST, both the blink counter and blink_phase are 0.
  - Outside LOST, blink_phase is held at 0 and the blink counter at 0.
  - First advance to phase 1 occurs BLINK_DIV cycles after the entry edge.
- No combinational path from inputs to outputs.

Test Plan (SCAN_DIV=4, BLINK_DIV=8 unless noted):
1. Reset then idle 20 cycles → lost=0, playing=0, score_bcd=16'h0000; scan_tick pulses exactly every 4th cycle, first pulse on cycle 4 after reset release.
2. start, then 13 pipe_passed pulses → playing=1, score_bcd=16'h0013; also check the 9→10 carry: after 10 pulses score_bcd=16'h0010.
3. Saturation and carry chain:
   - Preload to 0999 via pulses, one more pulse → 16'h1000.
   - Drive to 9999, two more pulses → stays 16'h9999.
4. Game over and blink sequence:
   - score 0005, collision → lost=1 and playing=0 the next cycle; best_bcd=16'h0005.
   - blink_phase sequence 0,1,2,3,0 with each value held 8 cycles.
   - Further pipe_passed pulses leave score_bcd unchanged.
5. Simultaneous collision and pipe_passed at score 0007 → LOST, score_bcd=16'h0007, best=16'h0007. Then start, 3 pipes, collision → best_bcd stays 16'h0007, score_bcd=16'h0003.
6. Reset mid-LOST at blink_phase=2 → next cycle all outputs 0, state IDLE. Also check that start during PLAY does not clear the score.
